// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block: mode/direction encodings
// and default sizing used by pwm_multi and pwm_prescaler.
package pwm_pkg;

    localparam int CH_DEFAULT    = 4;
    localparam int R_DEFAULT     = 8;
    localparam int TIMER_DEFAULT = 16;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } count_dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Programmable prescaler: counts 0..final_value and emits a one-clock tick at
// the terminal count; a lowered final_value ticks on the next enabled clock.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int TIMER = TIMER_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [TIMER-1:0] final_value,
    output logic             tick
);

    localparam logic [TIMER-1:0] CNT_ONE = {{(TIMER-1){1'b0}}, 1'b1};

    logic [TIMER-1:0] count;

    // >= rather than == so a terminal count moved below the running count
    // still terminates the cycle immediately.
    assign tick = en && (count >= final_value);

    // NOTE: sequential state uses non-blocking assignment so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with shared edge/center-aligned counter and
// shadowed duty/mode registers that take effect only at period boundaries.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CH    = CH_DEFAULT,
    parameter int R     = R_DEFAULT,
    parameter int TIMER = TIMER_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [TIMER-1:0]      final_value,
    input  logic [CH*(R+1)-1:0]   duty,
    input  logic                  mode,
    input  logic                  update,
    output logic [CH-1:0]         pwm_out,
    output logic                  period_end,
    output logic                  update_ack
);

    localparam int          DW    = R + 1;
    localparam logic [R-1:0] Q_MAX = '1;
    localparam logic [R-1:0] Q_ONE = {{(R-1){1'b0}}, 1'b1};

    logic            tick;
    logic            boundary;
    logic [R-1:0]    q;
    count_dir_e      dir;
    pwm_mode_e       active_mode;
    pwm_mode_e       shadow_mode;
    logic            pending;
    logic [DW-1:0]   active_duty [CH];
    logic [DW-1:0]   shadow_duty [CH];

    pwm_prescaler #(
        .TIMER (TIMER)
    ) u_prescaler (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .final_value (final_value),
        .tick        (tick)
    );

    // NOTE: default assigned first so no path through the block infers a latch.
    always_comb begin
        boundary = 1'b0;
        if (tick) begin
            if (active_mode == MODE_EDGE) begin
                boundary = (q == Q_MAX);
            end else begin
                boundary = (dir == DIR_DOWN) && (q == Q_ONE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q           <= '0;
            dir         <= DIR_UP;
            active_mode <= MODE_EDGE;
            shadow_mode <= MODE_EDGE;
            pending     <= 1'b0;
            pwm_out     <= '0;
            period_end  <= 1'b0;
            update_ack  <= 1'b0;
            // NOTE: the duty banks are plain flops, so they are reset like any other state.
            for (int i = 0; i < CH; i++) begin
                active_duty[i] <= '0;
                shadow_duty[i] <= '0;
            end
        end else begin
            period_end <= boundary;
            update_ack <= boundary && pending;

            if (tick) begin
                for (int i = 0; i < CH; i++) begin
                    pwm_out[i] <= ({1'b0, q} < active_duty[i]);
                end
                // Every boundary, including a mode switch, restarts at Q=0 counting up.
                if (boundary) begin
                    q   <= '0;
                    dir <= DIR_UP;
                end else if (active_mode == MODE_EDGE) begin
                    q <= q + Q_ONE;
                end else if (dir == DIR_UP) begin
                    if (q == Q_MAX) begin
                        dir <= DIR_DOWN;
                        q   <= q - Q_ONE;
                    end else begin
                        q <= q + Q_ONE;
                    end
                end else begin
                    q <= q - Q_ONE;
                end
            end

            if (boundary && pending) begin
                active_mode <= shadow_mode;
                for (int i = 0; i < CH; i++) begin
                    active_duty[i] <= shadow_duty[i];
                end
            end

            // A capture in the boundary clock keeps pending set for the next boundary.
            if (update) begin
                shadow_mode <= pwm_mode_e'(mode);
                pending     <= 1'b1;
                for (int i = 0; i < CH; i++) begin
                    shadow_duty[i] <= duty[i*DW +: DW];
                end
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: an R=8 and an R=4 instance share control
// inputs and are compared every cycle against a position-in-period model.
module tb_pwm_multi;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] fv;
    logic        mode;
    logic        update;
    logic [35:0] duty8;
    logic [19:0] duty4;
    logic [3:0]  pwm_o [2];
    logic        pe_o  [2];
    logic        ack_o [2];

    int dv [2][4];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: prescaler count and position within the current period.
    int       m_cnt  [2];
    int       m_p    [2];
    int       m_mode [2];
    int       m_pend [2];
    int       m_shm  [2];
    int       m_sh   [2][4];
    int       m_act  [2][4];
    bit [3:0] m_out  [2];
    bit       m_pe   [2];
    bit       m_ack  [2];
    bit       model_valid = 1'b0;

    int s_hi [4];
    int s_pe;
    int s_ack;

    pwm_multi #(.CH(4), .R(8), .TIMER(16)) dut8 (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .final_value (fv),
        .duty        (duty8),
        .mode        (mode),
        .update      (update),
        .pwm_out     (pwm_o[0]),
        .period_end  (pe_o[0]),
        .update_ack  (ack_o[0])
    );

    pwm_multi #(.CH(4), .R(4), .TIMER(16)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .final_value (fv),
        .duty        (duty4),
        .mode        (mode),
        .update      (update),
        .pwm_out     (pwm_o[1]),
        .period_end  (pe_o[1]),
        .update_ack  (ack_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        duty8 = '0;
        duty4 = '0;
        for (int i = 0; i < 4; i++) begin
            duty8[i*9 +: 9] = 9'(dv[0][i]);
            duty4[i*5 +: 5] = 5'(dv[1][i]);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output value of a tick is (Q < duty), where Q follows from the
    // position p inside the period: edge Q=p, center Q=p up to max then 2*max-p.
    function automatic void model_step(input int k, input int r);
        int  q_max;
        int  len;
        int  q;
        bit  tk;
        if (reset) begin
            m_cnt[k] = 0; m_p[k] = 0; m_mode[k] = 0; m_pend[k] = 0; m_shm[k] = 0;
            m_out[k] = '0; m_pe[k] = 1'b0; m_ack[k] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_sh[k][i]  = 0;
                m_act[k][i] = 0;
            end
            return;
        end
        m_pe[k]  = 1'b0;
        m_ack[k] = 1'b0;
        tk = en && (m_cnt[k] >= int'(fv));
        if (tk) begin
            q_max = (1 << r) - 1;
            len   = (m_mode[k] == 0) ? (1 << r) : 2 * q_max;
            q     = (m_mode[k] == 0 || m_p[k] <= q_max) ? m_p[k] : 2 * q_max - m_p[k];
            for (int i = 0; i < 4; i++) m_out[k][i] = (q < m_act[k][i]);
            m_p[k]++;
            if (m_p[k] == len) begin
                m_p[k]  = 0;
                m_pe[k] = 1'b1;
                if (m_pend[k] != 0) begin
                    for (int i = 0; i < 4; i++) m_act[k][i] = m_sh[k][i];
                    m_mode[k] = m_shm[k];
                    m_pend[k] = 0;
                    m_ack[k]  = 1'b1;
                end
            end
            m_cnt[k] = 0;
        end else if (en) begin
            m_cnt[k]++;
        end
        if (update) begin
            for (int i = 0; i < 4; i++) m_sh[k][i] = dv[k][i];
            m_shm[k]  = int'(mode);
            m_pend[k] = 1;
        end
    endfunction

    always @(posedge clk) begin
        model_step(0, 8);
        model_step(1, 4);
        model_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("dut%0d pwm_out", k), 32'(pwm_o[k]), 32'(m_out[k]));
                check($sformatf("dut%0d period_end", k), 32'(pe_o[k]), 32'(m_pe[k]));
                check($sformatf("dut%0d update_ack", k), 32'(ack_o[k]), 32'(m_ack[k]));
            end
        end
    end

    task automatic pulse_update();
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_pulse(input int k, input bit want_ack, input int budget,
                              input string tag, output int waited);
        logic s;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
            s = want_ack ? ack_o[k] : pe_o[k];
        end while (s !== 1'b1 && waited < budget);
        check({tag, " arrives in budget"}, 32'(s === 1'b1), 32'd1);
    endtask

    task automatic sample(input int k, input int n);
        for (int i = 0; i < 4; i++) s_hi[i] = 0;
        s_pe  = 0;
        s_ack = 0;
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (pwm_o[k][i] === 1'b1) s_hi[i]++;
            if (pe_o[k] === 1'b1) s_pe++;
            if (ack_o[k] === 1'b1) s_ack++;
        end
    endtask

    initial begin
        int       w;
        int       hi;
        int       pe_n;
        int       asym;
        int       chg;
        bit       rec [30];
        logic [3:0] snap [2];

        reset = 1'b1; en = 1'b1; fv = '0; mode = 1'b0; update = 1'b0;
        for (int k = 0; k < 2; k++) for (int i = 0; i < 4; i++) dv[k][i] = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset dut%0d pwm_out", k), 32'(pwm_o[k]), 32'd0);
            check($sformatf("reset dut%0d period_end", k), 32'(pe_o[k]), 32'd0);
            check($sformatf("reset dut%0d update_ack", k), 32'(ack_o[k]), 32'd0);
        end
        reset = 1'b0;

        // Edge mode, tick every clock: ch0=64, ch1=0, ch2=full, ch3=half.
        dv[0] = '{64, 0, 256, 128};
        dv[1] = '{8, 0, 16, 31};
        pulse_update();
        wait_pulse(0, 1'b1, 600, "edge ack", w);
        check("edge ack with period_end", 32'(pe_o[0]), 32'd1);
        sample(0, 512);
        check("edge ch0 high of 512", s_hi[0], 128);
        check("edge ch1 duty0 high of 512", s_hi[1], 0);
        check("edge ch2 duty256 high of 512", s_hi[2], 512);
        check("edge ch3 high of 512", s_hi[3], 256);
        check("edge period_end in 512", s_pe, 2);

        // Center mode on the R=4 instance, duty 8.
        mode = 1'b1;
        pulse_update();
        wait_pulse(1, 1'b1, 64, "center ack", w);
        hi = 0; pe_n = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            rec[j] = (pwm_o[1][0] === 1'b1);
            if (rec[j]) hi++;
            if (pe_o[1] === 1'b1) pe_n++;
        end
        asym = 0;
        for (int j = 1; j < 15; j++) if (rec[j] != rec[30 - j]) asym++;
        check("center high ticks of 30", hi, 15);
        check("center period_end in 30", pe_n, 1);
        check("center asymmetric positions", asym, 0);
        check("center peak sample low", 32'(rec[15]), 32'd0);

        // Back to edge with duty 32, then a mid-period change to 200.
        mode = 1'b0;
        dv[0][0] = 32;
        pulse_update();
        wait_pulse(0, 1'b1, 600, "edge32 ack", w);
        repeat (100) @(negedge clk);
        dv[0][0] = 200;
        pulse_update();
        wait_pulse(0, 1'b1, 300, "duty200 ack", w);
        check("duty200 ack with period_end", 32'(pe_o[0]), 32'd1);
        sample(0, 256);
        check("duty200 ch0 high of 256", s_hi[0], 200);

        // Update landing exactly on the boundary clock.
        wait_pulse(0, 1'b0, 300, "pre-coincide period_end", w);
        repeat (255) @(negedge clk);
        dv[0][0] = 100;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        check("coincide period_end", 32'(pe_o[0]), 32'd1);
        check("coincide no ack", 32'(ack_o[0]), 32'd0);
        wait_pulse(0, 1'b1, 300, "coincide ack", w);
        check("coincide ack one period later", w, 256);
        sample(0, 256);
        check("duty100 ch0 high of 256", s_hi[0], 100);

        // Two updates before one boundary: the second wins.
        dv[0][0] = 10;
        pulse_update();
        repeat (5) @(negedge clk);
        dv[0][0] = 20;
        pulse_update();
        wait_pulse(0, 1'b1, 300, "double ack", w);
        sample(0, 256);
        check("double update ch0 high of 256", s_hi[0], 20);

        // Prescaler at 4 clocks per tick: R=4 edge period is 64 clocks.
        fv = 16'd3;
        wait_pulse(1, 1'b0, 200, "fv3 first period_end", w);
        wait_pulse(1, 1'b0, 200, "fv3 second period_end", w);
        check("fv3 period clocks", w, 64);

        // Freeze for 10 clocks while an update is captured.
        repeat (20) @(negedge clk);
        snap[0] = pwm_o[0];
        snap[1] = pwm_o[1];
        en = 1'b0;
        dv[0][0] = 50;
        dv[1][0] = 4;
        chg = 0; pe_n = 0;
        for (int j = 0; j < 10; j++) begin
            if (j == 3) update = 1'b1;
            @(negedge clk);
            update = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (pwm_o[k] !== snap[k]) chg++;
                if (pe_o[k] !== 1'b0 || ack_o[k] !== 1'b0) pe_n++;
            end
        end
        check("frozen pwm_out changes", chg, 0);
        check("frozen pulses", pe_n, 0);
        en = 1'b1;

        // Lower the terminal count below the running count, then restore it.
        repeat (2) @(negedge clk);
        fv = 16'd1;
        repeat (20) @(negedge clk);
        fv = 16'd3;
        repeat (30) @(negedge clk);

        // Reset mid-period with an update still pending.
        dv[0][0] = 77;
        dv[1][0] = 12;
        pulse_update();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("midreset dut%0d pwm_out", k), 32'(pwm_o[k]), 32'd0);
            check($sformatf("midreset dut%0d period_end", k), 32'(pe_o[k]), 32'd0);
            check($sformatf("midreset dut%0d update_ack", k), 32'(ack_o[k]), 32'd0);
        end
        reset = 1'b0;
        sample(1, 300);
        check("post-reset dut1 acks", s_ack, 0);
        check("post-reset dut1 period_end", s_pe, 4);
        check("post-reset dut1 high", s_hi[0] + s_hi[1] + s_hi[2] + s_hi[3], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
